// File: rtl/fp_pkg.sv
// ============================================================================
// fp_pkg : field layout, widths and FSM encoding for the 13-bit float path
// Revision 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FP_W     = 13;
    localparam int INT_W    = 8;
    localparam int SIGN_BIT = 12;
    localparam int EXP_MSB  = 11;
    localparam int EXP_LSB  = 8;
    localparam int FRAC_MSB = 7;
    localparam int FRAC_LSB = 0;
    localparam int MAX_EXP  = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CONV = ST_CONV,
        S_RESP = ST_RESP
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_to_int_core.sv
// ============================================================================
// fp_to_int_core : combinational 13-bit float to 8-bit sign/magnitude
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_to_int_core
    import fp_pkg::*;
(
    input  logic [FP_W-1:0]  i_fp,
    output logic [INT_W-1:0] o_int,
    output logic             of,
    output logic             uf
);

    logic [EXP_MSB-EXP_LSB:0]   w_exp;
    logic [FRAC_MSB-FRAC_LSB:0] w_frac;
    logic [INT_W-1:0]           w_mag;

    assign w_exp  = i_fp[EXP_MSB:EXP_LSB];
    assign w_frac = i_fp[FRAC_MSB:FRAC_LSB];

    // A zero fraction is an exact zero and never raises a flag
    always_comb begin
        w_mag = '0;
        of    = 1'b0;
        uf    = 1'b0;
        if (w_frac != '0) begin
            if (w_exp > 4'(MAX_EXP)) begin
                of = 1'b1;
            end else if (w_exp == '0) begin
                uf = 1'b1;
            end else begin
                w_mag = w_frac >> (4'd8 - w_exp);
            end
        end
    end

    assign o_int = {i_fp[SIGN_BIT], w_mag[INT_W-2:0]};

endmodule

`default_nettype wire

// File: rtl/fp_conv_arbiter.sv
// ============================================================================
// fp_conv_arbiter : round-robin sharing of one fp_to_int_core between A and B
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_conv_arbiter
    import fp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_valid,
    input  logic [FP_W-1:0]  a_fp,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [FP_W-1:0]  b_fp,
    output logic             b_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [INT_W-1:0] rsp_int,
    output logic             rsp_of,
    output logic             rsp_uf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] of_cnt,
    output logic [CNT_W-1:0] uf_cnt
);

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic [FP_W-1:0]    fp_q, fp_d;
    logic               id_q, id_d;
    logic [INT_W-1:0]   int_q, int_d;
    logic               of_q, of_d;
    logic               uf_q, uf_d;
    logic [CNT_W-1:0]   of_cnt_q, of_cnt_d;
    logic [CNT_W-1:0]   uf_cnt_q, uf_cnt_d;

    logic               w_grant_a;
    logic               w_grant_b;
    logic [INT_W-1:0]   w_int;
    logic               w_of;
    logic               w_uf;

    fp_to_int_core u_core (
        .i_fp  (fp_q),
        .o_int (w_int),
        .of    (w_of),
        .uf    (w_uf)
    );

    // prio_q: 0 favours A, 1 favours B; a lone requester always wins
    assign w_grant_a = a_valid && (!b_valid || !prio_q);
    assign w_grant_b = b_valid && (!a_valid ||  prio_q);

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        fp_d     = fp_q;
        id_d     = id_q;
        int_d    = int_q;
        of_d     = of_q;
        uf_d     = uf_q;
        of_cnt_d = of_cnt_q;
        uf_cnt_d = uf_cnt_q;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                a_ready = w_grant_a;
                b_ready = w_grant_b;
                if (w_grant_a || w_grant_b) begin
                    fp_d    = w_grant_b ? b_fp : a_fp;
                    id_d    = w_grant_b;
                    prio_d  = w_grant_a;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                int_d   = w_int;
                of_d    = w_of;
                uf_d    = w_uf;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if (of_q && (of_cnt_q != '1)) of_cnt_d = of_cnt_q + 1'b1;
                    if (uf_q && (uf_cnt_q != '1)) uf_cnt_d = uf_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear has priority over a coincident increment
        if (clr_cnt) begin
            of_cnt_d = '0;
            uf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            fp_q     <= '0;
            id_q     <= 1'b0;
            int_q    <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
            of_cnt_q <= '0;
            uf_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            fp_q     <= fp_d;
            id_q     <= id_d;
            int_q    <= int_d;
            of_q     <= of_d;
            uf_q     <= uf_d;
            of_cnt_q <= of_cnt_d;
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_int   = int_q;
    assign rsp_of    = of_q;
    assign rsp_uf    = uf_q;
    assign of_cnt    = of_cnt_q;
    assign uf_cnt    = uf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_conv_arbiter.sv
// ============================================================================
// tb_fp_conv_arbiter : directed self-checking bench for fp_conv_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fp_conv_arbiter;

    logic        r_clk       = 1'b0;
    logic        r_reset_n   = 1'b0;
    logic        r_a_valid   = 1'b0;
    logic        r_b_valid   = 1'b0;
    logic [12:0] r_a_fp      = '0;
    logic [12:0] r_b_fp      = '0;
    logic        r_rsp_ready = 1'b0;
    logic        r_clr_cnt   = 1'b0;

    logic        w_a_ready;
    logic        w_b_ready;
    logic        w_rsp_valid;
    logic        w_rsp_id;
    logic [7:0]  w_rsp_int;
    logic        w_rsp_of;
    logic        w_rsp_uf;
    logic [7:0]  w_of_cnt;
    logic [7:0]  w_uf_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 r_clk = ~r_clk;

    fp_conv_arbiter #(.CNT_W(8)) u_dut (
        .clk       (r_clk),
        .reset_n   (r_reset_n),
        .a_valid   (r_a_valid),
        .a_fp      (r_a_fp),
        .a_ready   (w_a_ready),
        .b_valid   (r_b_valid),
        .b_fp      (r_b_fp),
        .b_ready   (w_b_ready),
        .rsp_valid (w_rsp_valid),
        .rsp_ready (r_rsp_ready),
        .rsp_id    (w_rsp_id),
        .rsp_int   (w_rsp_int),
        .rsp_of    (w_rsp_of),
        .rsp_uf    (w_rsp_uf),
        .clr_cnt   (r_clr_cnt),
        .of_cnt    (w_of_cnt),
        .uf_cnt    (w_uf_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [12:0] a_vec(input int k);
        return {1'b0, 4'd4, 4'(k + 1), 4'h0};
    endfunction

    function automatic logic [12:0] b_vec(input int k);
        return {1'b1, 4'd4, 4'(k + 1), 4'h0};
    endfunction

    // One request from A (id=0) or B (id=1), checked through to its response
    task automatic run_one(input string tag, input bit id, input logic [12:0] fp,
                           input logic [7:0] e_int, input bit e_of, input bit e_uf, input bit clr);
        int k;
        @(negedge r_clk);
        if (id) begin r_b_valid = 1'b1; r_b_fp = fp; end
        else    begin r_a_valid = 1'b1; r_a_fp = fp; end
        #1;
        k = 0;
        while (((id ? w_b_ready : w_a_ready) !== 1'b1) && k < 20) begin
            @(negedge r_clk); #1; k++;
        end
        check_eq({tag, "_hs"}, 32'(k < 20), 1);
        @(posedge r_clk); #1;
        r_a_valid = 1'b0;
        r_b_valid = 1'b0;
        check_eq({tag, "_lat1"}, w_rsp_valid, 0);
        @(posedge r_clk); #1;
        check_eq({tag, "_valid"}, w_rsp_valid, 1);
        check_eq({tag, "_id"},    w_rsp_id,    32'(id));
        check_eq({tag, "_int"},   w_rsp_int,   e_int);
        check_eq({tag, "_of"},    w_rsp_of,    32'(e_of));
        check_eq({tag, "_uf"},    w_rsp_uf,    32'(e_uf));
        @(negedge r_clk);
        r_rsp_ready = 1'b1;
        r_clr_cnt   = clr;
        @(posedge r_clk); #1;
        r_rsp_ready = 1'b0;
        r_clr_cnt   = 1'b0;
        check_eq({tag, "_done"}, w_rsp_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ia, ib, ng, nr, n, bad_out, bad_rdy, seen, k;

        // Reset state with both requesters already valid
        r_a_valid   = 1'b1;
        r_b_valid   = 1'b1;
        r_a_fp      = a_vec(0);
        r_b_fp      = b_vec(0);
        r_rsp_ready = 1'b1;
        #12;
        check_eq("rst_valid",  w_rsp_valid, 0);
        check_eq("rst_id",     w_rsp_id,    0);
        check_eq("rst_int",    w_rsp_int,   0);
        check_eq("rst_of",     w_rsp_of,    0);
        check_eq("rst_uf",     w_rsp_uf,    0);
        check_eq("rst_ofcnt",  w_of_cnt,    0);
        check_eq("rst_ufcnt",  w_uf_cnt,    0);
        check_eq("rst_aready", w_a_ready,   1);
        check_eq("rst_bready", w_b_ready,   0);

        // Round-robin with continuous demand from both sides
        @(negedge r_clk);
        r_reset_n = 1'b1;
        ia = 0; ib = 0; ng = 0; nr = 0;
        for (int c = 0; c < 80 && nr < 4; c++) begin
            r_a_fp = a_vec(ia);
            r_b_fp = b_vec(ib);
            #1;
            if (w_a_ready || w_b_ready) begin
                check_eq($sformatf("rr_grant%0d", ng), w_b_ready, 32'(ng % 2));
                if (w_a_ready) ia++;
                if (w_b_ready) ib++;
                ng++;
            end
            if (w_rsp_valid) begin
                check_eq($sformatf("rr_id%0d", nr), w_rsp_id, 32'(nr % 2));
                check_eq($sformatf("rr_int%0d", nr), w_rsp_int,
                         (nr % 2) ? 32'(8'h80 | 8'(nr / 2 + 1)) : 32'(nr / 2 + 1));
                nr++;
            end
            @(negedge r_clk);
        end
        check_eq("rr_count", nr, 4);
        r_a_valid = 1'b0;
        r_b_valid = 1'b0;
        @(posedge r_clk); #1;
        r_rsp_ready = 1'b0;

        // Conversion vectors and boundaries
        run_one("a_pos",  0, {1'b0, 4'd4, 8'hB0}, 8'h0B, 0, 0, 0);
        run_one("a_neg",  0, {1'b1, 4'd4, 8'hB0}, 8'h8B, 0, 0, 0);
        run_one("e7ff",   1, {1'b0, 4'd7, 8'hFF}, 8'h7F, 0, 0, 0);
        run_one("ovf",    0, {1'b0, 4'd9, 8'h01}, 8'h00, 1, 0, 0);
        run_one("ovf_n",  1, {1'b1, 4'd9, 8'h01}, 8'h80, 1, 0, 0);
        run_one("unf",    1, {1'b0, 4'd0, 8'h01}, 8'h00, 0, 1, 0);
        run_one("zero",   0, {1'b0, 4'd9, 8'h00}, 8'h00, 0, 0, 0);
        run_one("e1",     1, {1'b0, 4'd1, 8'h80}, 8'h01, 0, 0, 0);
        check_eq("cnt_of_after_vec", w_of_cnt, 2);
        check_eq("cnt_uf_after_vec", w_uf_cnt, 1);

        // Backpressure: A held in RESP while both sides request
        @(negedge r_clk);
        r_a_valid = 1'b1;
        r_a_fp    = {1'b0, 4'd4, 8'hB0};
        #1;
        k = 0;
        while (w_a_ready !== 1'b1 && k < 20) begin @(negedge r_clk); #1; k++; end
        check_eq("bp_hs", 32'(k < 20), 1);
        @(posedge r_clk); #1;
        r_a_valid = 1'b0;
        @(posedge r_clk); #1;
        r_a_valid = 1'b1;
        r_b_valid = 1'b1;
        bad_out = 0;
        bad_rdy = 0;
        repeat (10) begin
            @(negedge r_clk); #1;
            if (w_rsp_valid !== 1'b1 || w_rsp_int !== 8'h0B || w_rsp_id !== 1'b0 ||
                w_rsp_of !== 1'b0 || w_rsp_uf !== 1'b0) bad_out++;
            if (w_a_ready !== 1'b0 || w_b_ready !== 1'b0) bad_rdy++;
        end
        check_eq("bp_stable", bad_out, 0);
        check_eq("bp_ready0", bad_rdy, 0);
        r_rsp_ready = 1'b1;
        @(posedge r_clk); #1;
        r_rsp_ready = 1'b0;
        check_eq("bp_release", w_rsp_valid, 0);
        check_eq("bp_idle_b",  w_b_ready,   1);
        check_eq("bp_idle_a",  w_a_ready,   0);
        r_a_valid = 1'b0;
        r_b_valid = 1'b0;
        check_eq("bp_ofcnt", w_of_cnt, 2);

        // Counters: clear, increment, saturation, clear beats increment
        @(negedge r_clk);
        r_clr_cnt = 1'b1;
        @(posedge r_clk); #1;
        r_clr_cnt = 1'b0;
        check_eq("clr_of", w_of_cnt, 0);
        check_eq("clr_uf", w_uf_cnt, 0);
        run_one("cnt1", 0, {1'b0, 4'd9, 8'h01}, 8'h00, 1, 0, 0);
        check_eq("cnt_inc1", w_of_cnt, 1);

        r_a_fp      = {1'b0, 4'd9, 8'h01};
        r_a_valid   = 1'b1;
        r_rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 3000 && n < 300; c++) begin
            @(negedge r_clk); #1;
            if (w_rsp_valid) n++;
        end
        r_a_valid = 1'b0;
        @(posedge r_clk); #1;
        r_rsp_ready = 1'b0;
        check_eq("sat_count", n, 300);
        check_eq("sat_of", w_of_cnt, 255);
        check_eq("sat_uf", w_uf_cnt, 0);

        run_one("clr_hs", 0, {1'b0, 4'd9, 8'h01}, 8'h00, 1, 0, 1);
        check_eq("clr_wins", w_of_cnt, 0);
        run_one("unf2", 0, {1'b0, 4'd0, 8'h01}, 8'h00, 0, 1, 0);
        check_eq("uf_inc", w_uf_cnt, 1);

        // Reset while in CONV; prio had moved to B beforehand
        @(negedge r_clk);
        r_a_valid = 1'b1;
        r_a_fp    = {1'b0, 4'd4, 8'hB0};
        #1;
        k = 0;
        while (w_a_ready !== 1'b1 && k < 20) begin @(negedge r_clk); #1; k++; end
        check_eq("mr_hs", 32'(k < 20), 1);
        @(posedge r_clk); #1;
        r_a_valid = 1'b0;
        #1;
        r_reset_n = 1'b0;
        #1;
        check_eq("mr_valid", w_rsp_valid, 0);
        check_eq("mr_int",   w_rsp_int,   0);
        check_eq("mr_ufcnt", w_uf_cnt,    0);
        check_eq("mr_ofcnt", w_of_cnt,    0);
        #1;
        r_reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge r_clk); #1;
            if (w_rsp_valid) seen++;
        end
        check_eq("mr_no_rsp", seen, 0);
        r_a_valid = 1'b1;
        r_b_valid = 1'b1;
        #1;
        check_eq("mr_prio_a", w_a_ready, 1);
        check_eq("mr_prio_b", w_b_ready, 0);
        r_a_valid = 1'b0;
        r_b_valid = 1'b0;

        @(negedge r_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_conv_arbiter.md
# fp_conv_arbiter

Shares one 13-bit-float-to-8-bit-sign/magnitude conversion datapath between two requesters (A and B). It runs a round-robin grant, valid/ready request handshakes, a registered response channel with backpressure, and saturating overflow/underflow event counters. It sits between client logic producing 13-bit floats and the single converter instance.

## Interface
- `CNT_W`, default 8: width of the overflow/underflow event counters.
- `clk` (in, 1): clock; all state is updated on the rising edge.
- `reset_n` (in, 1): asynchronous reset, active low.
- `a_valid` / `b_valid` (in, 1): requester has an operand.
- `a_fp` / `b_fp` (in, 13): operand; bit 12 sign, [11:8] exponent, [7:0] fraction.
- `a_ready` / `b_ready` (out, 1): request accepted this cycle when ready and valid are both high.
- `rsp_valid` (out, 1): result held on the response outputs.
- `rsp_ready` (in, 1): consumer takes the response.
- `rsp_id` (out, 1): requester of the response; 0 = A, 1 = B.
- `rsp_int` (out, 8): converted value, sign/magnitude.
- `rsp_of` / `rsp_uf` (out, 1): overflow / underflow flag for the response.
- `clr_cnt` (in, 1): synchronous clear of both counters.
- `of_cnt` / `uf_cnt` (out, CNT_W): saturating counts of delivered responses with the flag set.

## Operation
- **Conversion** (combinational, on the registered operand; exp = [11:8], frac = [7:0]):
  - frac == 0: magnitude 0, no flags. This takes priority over both flag cases.
  - else exp > 7: magnitude 0, of = 1.
  - else exp == 0: magnitude 0, uf = 1.
  - else magnitude = frac >> (8 − exp), which is an 8-bit logical shift.
  - rsp_int = {sign, magnitude[6:0]}. The sign passes through in every case, including zero and flagged results.
- **FSM states:** IDLE, CONV, RESP.
  - IDLE: the winning requester sees ready = 1; the loser sees 0. On handshake, capture the fp value and requester id, then go to CONV. With no valid request, stay in IDLE.
  - CONV: register the conversion result and flags, then go to RESP unconditionally.
  - RESP: rsp_valid = 1, outputs held stable. On rsp_ready, go to IDLE and update the counters.
- **Arbitration:**
  - Pointer `prio` resets to A.
  - Both requesters valid: the `prio` requester wins.
  - One requester valid: it wins regardless of `prio`.
  - After every grant, `prio` points to the requester that was not granted.
  - Both ready outputs are 0 outside IDLE.
- **Counters:**
  - On a response handshake with rsp_of = 1, of_cnt increments; likewise uf_cnt with rsp_uf.
  - Counters saturate at 2^CNT_W − 1.
  - clr_cnt coinciding with an increment: the clear wins and the counter reads 0.

## Timing
- **Reset values:** state IDLE, prio = A, rsp_valid = 0, rsp_id = 0, rsp_int = 0x00, rsp_of = 0, rsp_uf = 0, of_cnt = 0, uf_cnt = 0.
- **Ready outputs at reset:** a_ready and b_ready are combinational. They may be 1 in IDLE right after reset if the corresponding valid is high.
- **Latency:** request handshake at edge N, then rsp_valid high from edge N+2.
- **Throughput:** minimum 3 cycles per result. IDLE is always visited for one cycle after a response handshake; there is no back-to-back bypass.
- **Backpressure:** rsp_ready low holds RESP indefinitely with all response outputs stable. Requests stay blocked during this time.
- **Ready is independent of rsp_ready:** ready must not depend combinationally on rsp_ready.
- **Mid-operation reset:** asserting reset_n low in any state aborts the in-flight conversion with no response emitted, and all outputs return to reset values immediately (asynchronous).

## Structure
- **Shared package `fp_pkg`:**
  - field positions: SIGN_BIT = 12, EXP_MSB/LSB = 11/8, FRAC_MSB/LSB = 7/0;
  - FP_W = 13, INT_W = 8;
  - MAX_EXP = 7;
  - state encoding constants for IDLE/CONV/RESP.
- **Sub-module `fp_to_int_core`:** the combinational converter described above, with ports i_fp[12:0], o_int[7:0], of, uf. It is instantiated once. The arbiter, FSM, registers and counters live in the top block.

## Test plan
- **Single A request:** A sends 0_0100_10110000 → rsp at N+2 with id 0, rsp_int 0x0B, of 0, uf 0. Repeated with the sign set (1_0100_10110000) → 0x8B.
- **Boundaries:**
  - exp 7, frac 0xFF → 0x7F.
  - exp 9, frac 0x01 → 0x00 with of 1.
  - exp 0, frac 0x01 → 0x00 with uf 1.
  - exp 9, frac 0x00 → 0x00 with no flags.
  - exp 1, frac 0x80 → 0x01.
- **Round-robin:** A and B valid continuously from reset → grants in order A, B, A, B; rsp_id sequence 0, 1, 0, 1; each stream is received in order.
- **Backpressure:** rsp_ready low for 10 cycles in RESP → outputs stable, a_ready and b_ready held 0; on release, one handshake then IDLE.
- **Counters:** 300 overflow responses → of_cnt = 255 (saturated). clr_cnt asserted in the same cycle as an overflow handshake → of_cnt = 0.
- **Reset mid-CONV:** reset_n pulsed low in CONV → rsp_valid never asserts, prio = A, all counters 0.
